// File: rtl/wb_stage.sv
// Writeback stage: merges single-cycle pipeline results with a queue of
// long-latency results into one registered register-file write port.
module wb_stage #(
    parameter int REG_W      = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_D     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      p_valid,
    input  logic [REG_W-1:0]          p_rd,
    input  logic [DATA_W-1:0]         p_data,
    output logic                      p_stall,
    input  logic                      l_valid,
    output logic                      l_ready,
    input  logic [REG_W-1:0]          l_rd,
    input  logic [DATA_W-1:0]         l_data,
    output logic [REG_W-1:0]          rf_a3,
    output logic [DATA_W-1:0]         rf_wd,
    output logic                      rf_we,
    input  logic [REG_W-1:0]          q_addr,
    output logic                      q_pend,
    output logic [$clog2(FIFO_D):0]   occ
);

    localparam int AW = $clog2(FIFO_D);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_D);
    localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);

    logic [REG_W-1:0]  r_mem_rd [FIFO_D];
    logic [DATA_W-1:0] r_mem_wd [FIFO_D];
    logic [FIFO_D-1:0] r_vld;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_occ;
    logic [SW-1:0]     r_starve;
    logic [REG_W-1:0]  r_a3;
    logic [DATA_W-1:0] r_wd;
    logic              r_we;

    logic              w_empty;
    logic              w_take_p;
    logic              w_pop;
    logic              w_enq;
    logic              w_hit;
    logic [FIFO_D-1:0] w_vld_nxt;

    assign w_empty  = (r_occ == '0);
    assign l_ready  = rst_n && (r_occ < DEPTH);
    assign p_stall  = (r_starve == SMAX) && !w_empty;
    assign w_take_p = !p_stall && p_valid && (p_rd != '0);
    assign w_pop    = !w_empty && !w_take_p;
    assign w_enq    = l_valid && l_ready && (l_rd != '0);

    always_comb begin
        w_vld_nxt = r_vld;
        if (w_pop) w_vld_nxt[r_rptr] = 1'b0;
        if (w_enq) w_vld_nxt[r_wptr] = 1'b1;
    end

    // Hazard check covers every live queue slot plus the write in flight.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < FIFO_D; i++) begin
            if (r_vld[i] && (r_mem_rd[i] == q_addr)) w_hit = 1'b1;
        end
        if (r_we && (r_a3 == q_addr)) w_hit = 1'b1;
        q_pend = (q_addr != '0) && w_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_D; i++) begin
                r_mem_rd[i] <= '0;
                r_mem_wd[i] <= '0;
            end
            r_vld    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_occ    <= '0;
            r_starve <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (w_enq) begin
                r_mem_rd[r_wptr] <= l_rd;
                r_mem_wd[r_wptr] <= l_data;
                r_wptr           <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            if (w_pop || w_empty) r_starve <= '0;
            else if (r_starve != SMAX) r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            r_a3 <= '0;
            r_wd <= '0;
        end else begin
            unique case (1'b1)
                w_take_p: begin
                    r_we <= 1'b1;
                    r_a3 <= p_rd;
                    r_wd <= p_data;
                end
                w_pop: begin
                    r_we <= 1'b1;
                    r_a3 <= r_mem_rd[r_rptr];
                    r_wd <= r_mem_wd[r_rptr];
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

    assign rf_we = r_we;
    assign rf_a3 = r_a3;
    assign rf_wd = r_wd;
    assign occ   = r_occ;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: pipeline/queue arbitration, starvation,
// hazard query and reset behaviour.
module tb_wb_stage;

    localparam int REG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int FIFO_D     = 4;
    localparam int STARVE_MAX = 8;

    logic              clk;
    logic              rst_n;
    logic              p_valid;
    logic [REG_W-1:0]  p_rd;
    logic [DATA_W-1:0] p_data;
    logic              p_stall;
    logic              l_valid;
    logic              l_ready;
    logic [REG_W-1:0]  l_rd;
    logic [DATA_W-1:0] l_data;
    logic [REG_W-1:0]  rf_a3;
    logic [DATA_W-1:0] rf_wd;
    logic              rf_we;
    logic [REG_W-1:0]  q_addr;
    logic              q_pend;
    logic [2:0]        occ;

    logic [REG_W+DATA_W-1:0] wq[$];
    logic [REG_W+DATA_W-1:0] w_exp;
    logic acc;
    int n_chk = 0;
    int n_err = 0;

    wb_stage #(
        .REG_W(REG_W), .DATA_W(DATA_W),
        .FIFO_D(FIFO_D), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_stall(p_stall),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_we(rf_we),
        .q_addr(q_addr), .q_pend(q_pend), .occ(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && rf_we) wq.push_back({rf_a3, rf_wd});
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        p_valid = 1'b0;
        p_rd    = '0;
        p_data  = '0;
        l_valid = 1'b0;
        l_rd    = '0;
        l_data  = '0;
        q_addr  = 5'd5;
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_a3", rf_a3, 0);
        chk("rst_wd", rf_wd, 0);
        chk("rst_occ", occ, 0);
        chk("rst_stall", p_stall, 0);
        chk("rst_lrdy", l_ready, 0);
        chk("rst_qpend", q_pend, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_we", rf_we, 0);
        chk("post_rst_lrdy", l_ready, 1);

        // single pipeline write
        p_valid = 1'b1; p_rd = 5'd5; p_data = 32'hA5;
        tick();
        p_valid = 1'b0;
        chk("p_we", rf_we, 1);
        chk("p_a3", rf_a3, 5);
        chk("p_wd", rf_wd, 32'hA5);
        tick();
        chk("p_we_drop", rf_we, 0);

        // fill queue behind pipeline traffic, then drain in order
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            p_valid = 1'b1; p_rd = 5'd9; p_data = 32'h99;
            l_valid = 1'b1; l_rd = 5'(i + 1); l_data = 32'h101 + 32'(i);
            chk("fill_rdy", l_ready, 1);
            tick();
        end
        p_valid = 1'b0;
        l_rd = 5'd5; l_data = 32'h105;
        chk("full_occ", occ, 4);
        chk("full_rdy", l_ready, 0);
        for (int k = 0; k < 10; k++) begin
            acc = l_valid && l_ready;
            tick();
            if (acc) l_valid = 1'b0;
        end
        chk("drain_lvalid", l_valid, 0);
        chk("drain_occ", occ, 0);
        chk("drain_cnt", wq.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < 4) w_exp = {5'd9, 32'h99};
            else w_exp = {5'(i - 3), 32'h100 + 32'(i - 3)};
            if (i < wq.size()) chk("drain_order", wq[i], w_exp);
        end

        // starvation: held pipeline traffic vs one queued entry
        p_valid = 1'b1; p_rd = 5'd6; p_data = 32'h66;
        l_valid = 1'b1; l_rd = 5'd3; l_data = 32'h33;
        tick();
        l_valid = 1'b0;
        chk("starve_occ", occ, 1);
        for (int k = 0; k < 8; k++) begin
            chk("starve_wait", p_stall, 0);
            tick();
        end
        chk("starve_stall", p_stall, 1);
        tick();
        chk("starve_we", rf_we, 1);
        chk("starve_a3", rf_a3, 3);
        chk("starve_wd", rf_wd, 32'h33);
        chk("starve_release", p_stall, 0);
        chk("starve_occ0", occ, 0);
        tick();
        chk("starve_p_a3", rf_a3, 6);
        p_valid = 1'b0;
        tick();

        // rd==0 on both paths
        wq.delete();
        p_valid = 1'b1; p_rd = 5'd0; p_data = 32'hDEAD;
        l_valid = 1'b1; l_rd = 5'd0; l_data = 32'hBEEF;
        for (int k = 0; k < 3; k++) begin
            chk("x0_lrdy", l_ready, 1);
            tick();
            chk("x0_occ", occ, 0);
            chk("x0_we", rf_we, 0);
        end
        p_valid = 1'b0; l_valid = 1'b0;
        tick();
        chk("x0_cnt", wq.size(), 0);

        // hazard query
        q_addr = 5'd7;
        p_valid = 1'b1; p_rd = 5'd6; p_data = 32'h66;
        l_valid = 1'b1; l_rd = 5'd7; l_data = 32'h77;
        #1 chk("q_before", q_pend, 0);
        tick();
        l_valid = 1'b0;
        chk("q_queued", q_pend, 1);
        q_addr = 5'd0;
        #1 chk("q_zero", q_pend, 0);
        q_addr = 5'd7;
        p_valid = 1'b0;
        tick();
        chk("q_out_we", rf_we, 1);
        chk("q_out_a3", rf_a3, 7);
        chk("q_out", q_pend, 1);
        tick();
        chk("q_done", q_pend, 0);

        // reset mid-operation with three queued entries
        p_valid = 1'b1; p_rd = 5'd6; p_data = 32'h66;
        for (int i = 0; i < 3; i++) begin
            l_valid = 1'b1; l_rd = 5'(10 + i); l_data = 32'h200 + 32'(i);
            tick();
        end
        l_valid = 1'b0;
        q_addr = 5'd10;
        chk("mr_occ", occ, 3);
        chk("mr_we", rf_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst_occ", occ, 0);
        chk("mr_rst_we", rf_we, 0);
        chk("mr_rst_a3", rf_a3, 0);
        chk("mr_rst_lrdy", l_ready, 0);
        chk("mr_rst_qpend", q_pend, 0);
        p_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        wq.delete();
        repeat (4) tick();
        chk("mr_stale", wq.size(), 0);
        chk("mr_occ_after", occ, 0);
        chk("mr_qpend_after", q_pend, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
